// File: rtl/xc_aessub_seq.sv
// xc_aessub_seq: sequences one 128-bit AES state through a 32-bit SubBytes
// responder, one column at a time. Each column is issued with a valid/ready
// handshake and followed by a one-cycle flush that re-arms the responder.
// A column that gets no sub_ready within 2^WAIT_W-1 issue cycles aborts the
// whole request with rsp_err set.
// Optional build macro XC_AESSUB_SEQ_FLUSH_RAND_EN: flush data comes from a
// free-running LFSR, and the state/result registers are wiped on leaving DONE.
module xc_aessub_seq #(
    parameter int WAIT_W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_state,
    input  logic         req_enc,
    input  logic         req_rot,
    output logic         sub_valid,
    output logic [31:0]  sub_rs1,
    output logic [31:0]  sub_rs2,
    output logic         sub_enc,
    output logic         sub_rot,
    output logic         sub_flush,
    output logic [31:0]  sub_flush_data,
    input  logic         sub_ready,
    input  logic [31:0]  sub_result,
    output logic         rsp_valid,
    output logic [127:0] rsp_state,
    output logic         rsp_err,
    input  logic         rsp_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

    seq_state_t          fsm;
    logic [1:0]          col;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_nxt;
    logic [127:0]        state_q;
    logic [127:0]        result_q;
    logic [6:0]          col_base;

    assign col_base  = {col, 5'd0};
    assign wait_nxt  = wait_cnt + 1'b1;

    // Both operands carry the same column so all four bytes get substituted.
    assign sub_rs1   = state_q[col_base +: 32];
    assign sub_rs2   = state_q[col_base +: 32];
    assign rsp_state = result_q;

    // Request sequencing FSM; all handshake outputs are registered here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm       <= S_IDLE;
            col       <= 2'd0;
            wait_cnt  <= '0;
            state_q   <= '0;
            result_q  <= '0;
            sub_enc   <= 1'b0;
            sub_rot   <= 1'b0;
            sub_valid <= 1'b0;
            sub_flush <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        state_q   <= req_state;
                        // Cleared so columns skipped by an abort read as 0.
                        result_q  <= '0;
                        sub_enc   <= req_enc;
                        sub_rot   <= req_rot;
                        col       <= 2'd0;
                        wait_cnt  <= '0;
                        req_ready <= 1'b0;
                        sub_valid <= 1'b1;
                        fsm       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (sub_ready) begin
                        result_q[col_base +: 32] <= sub_result;
                        sub_valid <= 1'b0;
                        sub_flush <= 1'b1;
                        fsm       <= S_FLUSH;
                    end else begin
                        wait_cnt <= wait_nxt;
                        if (wait_nxt == {WAIT_W{1'b1}}) begin
                            // Give up on the remaining columns; the flush still
                            // happens so the responder is left re-armed.
                            rsp_err   <= 1'b1;
                            col       <= 2'd3;
                            sub_valid <= 1'b0;
                            sub_flush <= 1'b1;
                            fsm       <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    sub_flush <= 1'b0;
                    wait_cnt  <= '0;
                    if (col == 2'd3) begin
                        rsp_valid <= 1'b1;
                        fsm       <= S_DONE;
                    end else begin
                        col       <= col + 2'd1;
                        sub_valid <= 1'b1;
                        fsm       <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
`ifdef XC_AESSUB_SEQ_FLUSH_RAND_EN
                        state_q   <= '0;
                        result_q  <= '0;
`endif
                        fsm       <= S_IDLE;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

`ifdef XC_AESSUB_SEQ_FLUSH_RAND_EN
    logic [31:0] lfsr;

    // Galois LFSR, taps 32,22,2,1; scrubs stale responder bytes on flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr <= 32'hACE1_2468;
        end else begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
        end
    end

    assign sub_flush_data = lfsr;
`else
    assign sub_flush_data = 32'h0;
`endif

endmodule

// File: tb/tb_xc_aessub_seq.sv
// Bench for xc_aessub_seq: behavioural SubBytes responders (single-cycle,
// four-cycle with flush re-arm, and one that stops answering after N columns)
// plus a reference model built from GF(2^8) arithmetic.
module tb_xc_aessub_seq;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_state;
    logic         req_enc;
    logic         req_rot;
    logic         sub_valid;
    logic [31:0]  sub_rs1;
    logic [31:0]  sub_rs2;
    logic         sub_enc;
    logic         sub_rot;
    logic         sub_flush;
    logic [31:0]  sub_flush_data;
    logic         sub_ready;
    logic [31:0]  sub_result;
    logic         rsp_valid;
    logic [127:0] rsp_state;
    logic         rsp_err;
    logic         rsp_ready;

    int nchk  = 0;
    int npass = 0;

    logic [7:0] sbox_t [256];
    logic [7:0] isbox_t[256];

    // responder configuration / bookkeeping
    logic         multi     = 1'b0;
    int           dead_from = 4;
    int           hs_cnt    = 0;
    int           hs_base   = 0;
    int           fl_cnt    = 0;
    logic [1:0]   mcnt;
    logic [127:0] cur_state = '0;
    logic         cur_enc   = 1'b0;

    xc_aessub_seq #(.WAIT_W(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_state(req_state),
        .req_enc(req_enc), .req_rot(req_rot),
        .sub_valid(sub_valid), .sub_rs1(sub_rs1), .sub_rs2(sub_rs2),
        .sub_enc(sub_enc), .sub_rot(sub_rot), .sub_flush(sub_flush),
        .sub_flush_data(sub_flush_data), .sub_ready(sub_ready),
        .sub_result(sub_result),
        .rsp_valid(rsp_valid), .rsp_state(rsp_state), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // AES word substitution as the responder is expected to produce it
    function automatic logic [31:0] sub_word(input logic [31:0] w, input logic enc, input logic rot);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = enc ? sbox_t[w[8*i +: 8]] : isbox_t[w[8*i +: 8]];
        return rot ? {r[23:0], r[31:24]} : r;
    endfunction

    // expected response: columns below 'live' substituted, the rest zero
    function automatic logic [127:0] model(input logic [127:0] s, input logic enc,
                                           input logic rot, input int live);
        logic [127:0] r = '0;
        for (int i = 0; i < 4; i++)
            if (i < live) r[32*i +: 32] = sub_word(s[32*i +: 32], enc, rot);
        return r;
    endfunction

    // responder: combinational single-cycle, or ready on 4th valid cycle
    always_comb begin
        sub_ready  = 1'b0;
        sub_result = sub_word(sub_rs1, sub_enc, sub_rot);
        if (sub_valid && (hs_cnt - hs_base) < dead_from)
            sub_ready = multi ? (mcnt == 2'd3) : 1'b1;
    end

    always @(posedge clock or posedge reset) begin
        if (reset) mcnt <= 2'd0;
        else if (sub_flush) mcnt <= 2'd0;
        else if (sub_valid && mcnt != 2'd3) mcnt <= mcnt + 2'd1;
    end

    always @(posedge clock) begin
        if (sub_valid && sub_ready) hs_cnt <= hs_cnt + 1;
        if (sub_flush) fl_cnt <= fl_cnt + 1;
    end

    // operand check at each accepted column
    always @(negedge clock) begin
        int idx;
        idx = hs_cnt - hs_base;
        if (!reset && sub_valid && sub_ready && idx >= 0 && idx < 4) begin
            chk("rs1", {96'h0, sub_rs1}, {96'h0, cur_state[32*idx +: 32]});
            chk("rs2", {96'h0, sub_rs2}, {96'h0, cur_state[32*idx +: 32]});
            chk("enc", {127'h0, sub_enc}, {127'h0, cur_enc});
        end
    end

    // one full request; returns the observed state and latency
    task automatic run_req(input logic [127:0] st, input logic enc, input logic rot,
                           input logic mc, input int dead, input int hold,
                           output logic [127:0] got, output int lat);
        int live, per, exp_lat, exp_fl, fl0;
        live = (dead < 4) ? dead : 4;
        per  = mc ? 5 : 2;
        exp_lat = (dead < 4) ? (live * per + 17) : (4 * per + 1);
        exp_fl  = (dead < 4) ? (live + 1) : 4;
        @(negedge clock);
        chk("req_ready_idle", {127'h0, req_ready}, 128'h1);
        multi = mc; dead_from = dead; hs_base = hs_cnt; fl0 = fl_cnt;
        cur_state = st; cur_enc = enc;
        req_state = st; req_enc = enc; req_rot = rot; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0; req_state = $urandom; req_enc = $urandom; req_rot = $urandom;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!rsp_valid && lat < 300);
        if (lat >= 300) begin
            chk("rsp_timeout", 128'h0, 128'h1);
            got = '0;
        end else begin
            got = rsp_state;
            chk("latency", lat, exp_lat);
            chk("rsp_state", rsp_state, model(st, enc, rot, live));
            chk("rsp_err", {127'h0, rsp_err}, {127'h0, (dead < 4)});
            for (int h = 0; h < hold; h++) begin
                @(negedge clock);
                chk("hold_valid", {127'h0, rsp_valid}, 128'h1);
                chk("hold_state", rsp_state, got);
                chk("hold_req_ready", {127'h0, req_ready}, 128'h0);
            end
            rsp_ready = 1'b1;
            @(posedge clock);
            #1 rsp_ready = 1'b0;
            @(negedge clock);
            chk("post_req_ready", {127'h0, req_ready}, 128'h1);
            chk("post_rsp_valid", {127'h0, rsp_valid}, 128'h0);
            chk("post_rsp_err", {127'h0, rsp_err}, 128'h0);
            chk("flush_count", fl_cnt - fl0, exp_fl);
        end
    endtask

    initial begin
        logic [127:0] got;
        int lat, n, seen;
        logic [7:0] inv;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            sbox_t[x] = inv ^ rl8(inv, 1) ^ rl8(inv, 2) ^ rl8(inv, 3) ^ rl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = 8'(x);

        reset = 1'b1; req_valid = 1'b0; req_state = '0; req_enc = 1'b0;
        req_rot = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("rst_req_ready", {127'h0, req_ready}, 128'h1);
        chk("rst_sub_valid", {127'h0, sub_valid}, 128'h0);
        chk("rst_sub_flush", {127'h0, sub_flush}, 128'h0);
        chk("rst_rsp_valid", {127'h0, rsp_valid}, 128'h0);
        chk("rst_rsp_err", {127'h0, rsp_err}, 128'h0);
        chk("rst_rsp_state", rsp_state, 128'h0);
`ifndef XC_AESSUB_SEQ_FLUSH_RAND_EN
        chk("rst_flush_data", {96'h0, sub_flush_data}, 128'h0);
`endif
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;

        // directed cases
        run_req('0, 1'b1, 1'b0, 1'b0, 4, 0, got, lat);
        chk("tp_zero_enc", got, {4{32'h63636363}});
        chk("tp_single_lat", lat, 9);
        run_req({96'h0, 32'h53535353}, 1'b1, 1'b0, 1'b1, 4, 0, got, lat);
        chk("tp_multi", got, {{3{32'h63636363}}, 32'hEDEDEDED});
        chk("tp_multi_lat", lat, 21);
        run_req({4{32'h63636363}}, 1'b0, 1'b0, 1'b0, 4, 0, got, lat);
        chk("tp_inv", got, 128'h0);
        run_req({96'h0, 32'h00000053}, 1'b1, 1'b1, 1'b1, 4, 0, got, lat);
        chk("tp_rot", got, {{3{32'h63636363}}, 32'h6363ED63});
        run_req({4{32'h01234567}}, 1'b1, 1'b0, 1'b0, 0, 0, got, lat);
        chk("tp_abort", got, 128'h0);
        run_req({4{32'h01234567}}, 1'b1, 1'b0, 1'b0, 4, 10, got, lat);
        run_req({4{32'h89abcdef}}, 1'b0, 1'b1, 1'b1, 2, 1, got, lat);

        // randomized requests
        for (int it = 0; it < 40; it++) begin
            run_req({$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 1'($urandom),
                    1'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : 4,
                    int'($urandom_range(0, 3)), got, lat);
        end

        // reset while column 2 is being issued
        @(negedge clock);
        multi = 1'b1; dead_from = 4; hs_base = hs_cnt;
        cur_state = {$urandom, $urandom, $urandom, $urandom}; cur_enc = 1'b1;
        req_state = cur_state; req_enc = 1'b1; req_rot = 1'b0; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        n = 0;
        while (!(sub_valid && (hs_cnt - hs_base) == 2) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("reach_col2", {127'h0, (n < 100)}, 128'h1);
        #2 reset = 1'b1;
        #1;
        chk("mid_sub_valid", {127'h0, sub_valid}, 128'h0);
        chk("mid_sub_flush", {127'h0, sub_flush}, 128'h0);
        chk("mid_rsp_valid", {127'h0, rsp_valid}, 128'h0);
        chk("mid_req_ready", {127'h0, req_ready}, 128'h1);
        chk("mid_rsp_state", rsp_state, 128'h0);
        @(negedge clock) reset = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clock);
            if (rsp_valid || sub_valid) seen++;
        end
        chk("no_rsp_after_reset", seen, 0);
        run_req({4{32'h00112233}}, 1'b1, 1'b0, 1'b0, 4, 0, got, lat);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
